ifetch: RTL and testbench

Instruction fetch stage of the Klaw core: owns the fetch PC, issues word requests to instruction memory over a request/grant/response handshake, buffers returned words with their PC in a small FIFO, and presents them to decode as `instr_v_q_o`/`instr_q_o`/`pc0_q_o`. It sits ahead of decode, honours decode back-pressure and redirects the PC on pipeline flush. At most one memory request is outstanding at any time.

---
 rtl/ifetch.sv | 132 +++++++++++++
 tb/tb_ifetch.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Klaw fetch stage: owns the fetch PC, runs a single-outstanding request
// handshake to instruction memory and buffers returned words for decode.
module ifetch #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_adr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            flush_v_q_i,
    input  logic [XLEN-1:0] flush_pc_q_i,
    input  logic            stall_i,
    output logic            instr_v_q_o,
    output logic [XLEN-1:0] instr_q_o,
    output logic [XLEN-1:0] pc0_q_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] adr_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic            stale_q;
    logic [XLEN-1:0] fifo_ins_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_q  [FIFO_DEPTH];
    logic [PW-1:0]   rd_q;
    logic [PW-1:0]   wr_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic            instr_v;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] flush_pc;

    always_comb begin
        flush_pc = flush_pc_q_i & ~XLEN'(3);
        instr_v  = (cnt_q != '0) && !flush_v_q_i;
        pop      = instr_v && !stall_i;
        // A response that lands on a flush cycle belongs to the old path.
        push     = (state_q == S_WAIT) && imem_rvalid_i
                   && !stale_q && !flush_v_q_i;
        cnt_d    = cnt_q;
        if (flush_v_q_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    assign imem_req_o  = (state_q == S_REQ);
    assign imem_adr_o  = adr_q;
    assign instr_v_q_o = instr_v;
    assign instr_q_o   = fifo_ins_q[rd_q];
    assign pc0_q_o     = fifo_pc_q[rd_q];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            fetch_pc_q <= RESET_PC;
            stale_q    <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_ins_q[i] <= '0;
                fifo_pc_q[i]  <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (flush_v_q_i) begin
                rd_q       <= '0;
                wr_q       <= '0;
                fetch_pc_q <= flush_pc;
            end else begin
                if (pop) begin
                    rd_q <= rd_q + 1'b1;
                end
                if (push) begin
                    fifo_ins_q[wr_q] <= imem_rdata_i;
                    fifo_pc_q[wr_q]  <= adr_q;
                    wr_q             <= wr_q + 1'b1;
                end
            end
            unique case (state_q)
                S_IDLE: begin
                    if (cnt_d < CW'(FIFO_DEPTH)) begin
                        state_q <= S_REQ;
                        adr_q   <= flush_v_q_i ? flush_pc : fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (flush_v_q_i) begin
                        stale_q <= 1'b1;
                    end
                    if (imem_gnt_i) begin
                        state_q <= S_WAIT;
                        // A flushed request must not advance the redirected PC.
                        if (!stale_q && !flush_v_q_i) begin
                            fetch_pc_q <= adr_q + XLEN'(4);
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q <= S_IDLE;
                        stale_q <= 1'b0;
                    end else if (flush_v_q_i) begin
                        stale_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: randomized memory/decode/flush stimulus checked against
// an in-order PC stream model, plus directed timing scenarios.
module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] KEY    = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_adr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        flush_v_q_i = 1'b0;
    logic [31:0] flush_pc_q_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        instr_v_q_o;
    logic [31:0] instr_q_o;
    logic [31:0] pc0_q_o;

    always #5 clk = ~clk;

    ifetch #(
        .XLEN(32),
        .RESET_PC(RST_PC),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .imem_req_o(imem_req_o),
        .imem_adr_o(imem_adr_o),
        .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .flush_v_q_i(flush_v_q_i),
        .flush_pc_q_i(flush_pc_q_i),
        .stall_i(stall_i),
        .instr_v_q_o(instr_v_q_o),
        .instr_q_o(instr_q_o),
        .pc0_q_o(pc0_q_o)
    );

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    logic        stall_g = 1'b0;
    logic        flush_g = 1'b0;
    logic [31:0] tgt_g = 32'h0;
    logic        noise = 1'b0;
    int          gmax = 0;
    int          rmin = 0;
    int          rmax = 0;
    logic [31:0] hold_adr = 32'h0;
    int          hold_cnt = 0;
    logic        flush_on_rv = 1'b0;
    logic [31:0] rv_tgt = 32'h0;
    logic        last_rv = 1'b0;

    // memory model
    logic        m_out = 1'b0;
    logic [31:0] m_adr = 32'h0;
    int          m_rc = 0;
    int          m_gc = 0;
    logic        m_pend = 1'b0;
    logic [31:0] m_padr = 32'h0;

    // decode-stream model
    logic [31:0] exp_pc = RST_PC;
    logic        prev_flush = 1'b0;
    logic        first_req_chk = 1'b0;
    int          delivered = 0;
    int          n_req = 0;
    int          since_rst = 0;
    int          first_v_at = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h (t=%0t)",
                         name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic        rv;
        logic        g;
        logic        fl;
        logic        done;
        logic [31:0] tg;
        @(posedge clk);
        #1;
        rv = 1'b0;
        g = 1'b0;
        done = 1'b0;
        imem_rdata_i = $urandom;
        since_rst++;
        if (m_out) begin
            if (m_rc == 0) begin
                rv = 1'b1;
                done = 1'b1;
                imem_rdata_i = word(m_adr);
            end else begin
                m_rc--;
            end
        end else if (noise && $urandom_range(0, 3) == 0) begin
            rv = 1'b1;
        end
        if (first_req_chk) begin
            chk("first_req", 32'(imem_req_o), 32'h1);
            chk("first_req_adr", imem_adr_o, RST_PC);
            first_req_chk = 1'b0;
        end
        if (imem_req_o) begin
            n_req++;
            chk("one_outstanding", 32'(m_out), 32'h0);
            chk("adr_align", {30'h0, imem_adr_o[1:0]}, 32'h0);
            if (m_pend) begin
                chk("adr_stable", imem_adr_o, m_padr);
            end else begin
                m_pend = 1'b1;
                m_padr = imem_adr_o;
            end
            if (hold_cnt > 0 && imem_adr_o == hold_adr) hold_cnt--;
            else if (m_gc == 0) g = 1'b1;
            else m_gc--;
        end else if (noise && $urandom_range(0, 3) == 0) begin
            g = 1'b1;
        end
        fl = flush_g;
        tg = tgt_g;
        if (flush_on_rv && done) begin
            fl = 1'b1;
            tg = rv_tgt;
            flush_on_rv = 1'b0;
        end
        imem_rvalid_i = rv;
        imem_gnt_i = g;
        flush_v_q_i = fl;
        flush_pc_q_i = tg;
        stall_i = stall_g;
        #1;
        if (fl) chk("v_during_flush", 32'(instr_v_q_o), 32'h0);
        if (prev_flush) chk("v_after_flush", 32'(instr_v_q_o), 32'h0);
        if (instr_v_q_o) begin
            chk("pc", pc0_q_o, exp_pc);
            chk("instr", instr_q_o, word(exp_pc));
            if (first_v_at == 0) first_v_at = since_rst;
        end
        if (fl) begin
            exp_pc = tg & ~32'h3;
        end else if (instr_v_q_o && !stall_i) begin
            exp_pc = exp_pc + 32'h4;
            delivered++;
        end
        if (done) m_out = 1'b0;
        if (imem_req_o && g) begin
            m_pend = 1'b0;
            m_out = 1'b1;
            m_adr = imem_adr_o;
            m_rc = int'($urandom_range(rmin, rmax));
            m_gc = int'($urandom_range(0, gmax));
        end
        prev_flush = fl;
        last_rv = rv;
    endtask

    // Memory keeps answering through reset; every such response is junk.
    task automatic do_reset(input int n);
        reset_n = 1'b0;
        flush_g = 1'b0;
        stall_g = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            imem_rvalid_i = 1'b1;
            imem_gnt_i = 1'b1;
            imem_rdata_i = $urandom;
            flush_v_q_i = 1'b0;
            stall_i = 1'b0;
            #1;
            chk("rst_req", 32'(imem_req_o), 32'h0);
            chk("rst_adr", imem_adr_o, 32'h0);
            chk("rst_v", 32'(instr_v_q_o), 32'h0);
            chk("rst_instr", instr_q_o, 32'h0);
            chk("rst_pc", pc0_q_o, 32'h0);
        end
        reset_n = 1'b1;
        m_out = 1'b0;
        m_pend = 1'b0;
        hold_cnt = 0;
        flush_on_rv = 1'b0;
        prev_flush = 1'b0;
        exp_pc = RST_PC;
        m_gc = int'($urandom_range(0, gmax));
        first_req_chk = 1'b1;
        since_rst = 0;
        first_v_at = 0;
        delivered = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        int d0;
        int ps;
        int pf;
        logic found;

        // zero-wait memory: latency and 1-per-3 throughput
        do_reset(2);
        repeat (3) step();
        chk("first_valid_cycle", 32'(first_v_at), 32'd3);
        chk("first_v", 32'(instr_v_q_o), 32'h1);
        chk("first_pc", pc0_q_o, 32'h0);
        chk("first_instr", instr_q_o, 32'hA5A5A5A5);
        step();
        chk("gap_v", 32'(instr_v_q_o), 32'h0);
        step();
        step();
        chk("second_pc", pc0_q_o, 32'h4);
        chk("second_instr", instr_q_o, 32'hA5A5A5A1);
        repeat (24) step();
        chk("throughput", 32'(delivered), 32'd10);

        // decode stall fills the buffer, then drains back-to-back
        do_reset(2);
        stall_g = 1'b1;
        repeat (6) step();
        r = n_req;
        repeat (4) step();
        chk("no_req_full", 32'(n_req), 32'(r));
        stall_g = 1'b0;
        step();
        chk("drain0_v", 32'(instr_v_q_o), 32'h1);
        chk("drain0_pc", pc0_q_o, 32'h0);
        step();
        chk("drain1_pc", pc0_q_o, 32'h4);
        chk("resume_req", 32'(imem_req_o), 32'h1);
        chk("resume_adr", imem_adr_o, 32'h8);
        repeat (6) step();

        // delayed grant at 0x10 with a flush inside the request
        do_reset(2);
        hold_adr = 32'h10;
        hold_cnt = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (imem_req_o && imem_adr_o == 32'h10) found = 1'b1;
        end
        chk("reach_0x10", 32'(found), 32'h1);
        flush_g = 1'b1;
        tgt_g = 32'h200;
        step();
        flush_g = 1'b0;
        chk("hold_adr2", imem_adr_o, 32'h10);
        step();
        chk("hold_adr3", imem_adr_o, 32'h10);
        step();
        chk("gnt_req", 32'(imem_req_o), 32'h1);
        chk("gnt_adr", imem_adr_o, 32'h10);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (imem_req_o) found = 1'b1;
        end
        chk("redirect_req", 32'(found), 32'h1);
        chk("redirect_adr", imem_adr_o, 32'h200);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (instr_v_q_o) found = 1'b1;
        end
        chk("redirect_v", 32'(found), 32'h1);
        chk("redirect_pc", pc0_q_o, 32'h200);

        // flush on the same cycle as a response
        flush_on_rv = 1'b1;
        rv_tgt = 32'h300;
        for (int i = 0; i < 10 && flush_on_rv; i++) step();
        chk("flush_rv_fired", 32'(flush_on_rv), 32'h0);
        step();
        chk("flush_rv_next_v", 32'(instr_v_q_o), 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (instr_v_q_o) found = 1'b1;
        end
        chk("refetch_v", 32'(found), 32'h1);
        chk("refetch_pc", pc0_q_o, 32'h300);

        // misaligned flush target while idle
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (last_rv) found = 1'b1;
        end
        chk("idle_sync", 32'(found), 32'h1);
        flush_g = 1'b1;
        tgt_g = 32'h103;
        step();
        flush_g = 1'b0;
        step();
        chk("align_req", 32'(imem_req_o), 32'h1);
        chk("align_adr", imem_adr_o, 32'h100);
        step();
        step();
        chk("align_v", 32'(instr_v_q_o), 32'h1);
        chk("align_pc", pc0_q_o, 32'h100);
        chk("align_instr", instr_q_o, 32'hA5A5A4A5);

        // reset while waiting for a slow response
        rmin = 4;
        rmax = 4;
        for (int i = 0; i < 20 && !m_out; i++) step();
        chk("in_wait", 32'(m_out), 32'h1);
        rmin = 0;
        rmax = 0;
        do_reset(2);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (instr_v_q_o) found = 1'b1;
        end
        chk("post_rst_v", 32'(found), 32'h1);
        chk("post_rst_pc", pc0_q_o, RST_PC);

        // randomized segments
        for (int seg = 0; seg < 20; seg++) begin
            gmax = int'($urandom_range(0, 3));
            rmin = 0;
            rmax = int'($urandom_range(0, 3));
            noise = 1'b1;
            ps = int'($urandom_range(0, 60));
            pf = int'($urandom_range(0, 10));
            if ($urandom_range(0, 3) == 0) do_reset(int'($urandom_range(1, 3)));
            repeat (150) begin
                stall_g = int'($urandom_range(0, 99)) < ps;
                flush_g = int'($urandom_range(0, 99)) < pf;
                if ($urandom_range(0, 3) == 0)
                    tgt_g = 32'hFFFFFFF0 | ($urandom & 32'hF);
                else
                    tgt_g = $urandom;
                step();
            end
            stall_g = 1'b0;
            flush_g = 1'b0;
            d0 = delivered;
            repeat (30) step();
            chk("progress", 32'(delivered > d0), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
